// File: rtl/fifo2axis_pixel_if.sv
// AXI4-Stream video bus carrying one pixel per beat.
// The master drives valid/data/user/last; the slave drives ready.
interface fifo2axis_pixel_if #(
  parameter int unsigned C_PIXEL_WIDTH = 8
) ();

  logic                     TVALID;
  logic [C_PIXEL_WIDTH-1:0] TDATA;
  logic                     TUSER;
  logic                     TLAST;
  logic                     TREADY;

  modport master (
    output TVALID,
    output TDATA,
    output TUSER,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TUSER,
    input  TLAST,
    output TREADY
  );

endinterface

// File: rtl/fifo2axis_pixel.sv
// Serialises FWFT FIFO words (tagged sof/eol) into an AXI4-Stream pixel stream.
// Each word carries C_ADATA_PIXELS pixels, LSB pixel first. TUSER marks the
// first pixel of a frame, TLAST the last pixel of a line. While soft_resetn is
// low the FIFO is drained and no new pixels are issued; a beat already on the
// bus is held until accepted. The m_axis interface must be built with the same
// C_PIXEL_WIDTH, and C_DATA_WIDTH must equal C_PIXEL_WIDTH * C_ADATA_PIXELS.
module fifo2axis_pixel #(
  parameter int unsigned C_PIXEL_WIDTH  = 8,
  parameter int unsigned C_ADATA_PIXELS = 4,
  parameter int unsigned C_DATA_WIDTH   = 32
) (
  input  logic                    M_AXIS_ACLK,
  input  logic                    M_AXIS_ARESETN,
  input  logic                    soft_resetn,
  output logic                    resetting,
  input  logic                    fifo_empty,
  input  logic                    fifo_sof,
  input  logic                    fifo_eol,
  input  logic [C_DATA_WIDTH-1:0] fifo_dout,
  output logic                    fifo_rd_en,
  fifo2axis_pixel_if.master       m_axis
);

  localparam int unsigned IdxW = (C_ADATA_PIXELS > 1) ? $clog2(C_ADATA_PIXELS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(C_ADATA_PIXELS - 1);

  // Holding register for the word currently being serialised
  logic [C_DATA_WIDTH-1:0]  word_q;
  logic                     w_sof_q;
  logic                     w_eol_q;
  logic                     word_valid_q;
  logic [IdxW-1:0]          pix_idx_q;

  // Output register
  logic                     tvalid_q;
  logic [C_PIXEL_WIDTH-1:0] tdata_q;
  logic                     tuser_q;
  logic                     tlast_q;
  logic                     resetting_q;

  logic                     out_ready;
  logic                     last_pix;
  logic                     pix_load;
  logic                     pop;
  logic [C_PIXEL_WIDTH-1:0] pix_data;

  assign out_ready = ~tvalid_q | m_axis.TREADY;
  assign pix_load  = out_ready & word_valid_q & soft_resetn;
  assign last_pix  = word_valid_q & out_ready & (pix_idx_q == LastIdx);
  // During soft reset everything in the FIFO is discarded.
  assign pop       = soft_resetn ? (~fifo_empty & (~word_valid_q | last_pix)) : ~fifo_empty;

  assign fifo_rd_en    = pop;
  assign resetting     = resetting_q;
  assign m_axis.TVALID = tvalid_q;
  assign m_axis.TDATA  = tdata_q;
  assign m_axis.TUSER  = tuser_q;
  assign m_axis.TLAST  = tlast_q;

  // Select the pixel addressed by pix_idx from the held word
  always_comb begin
    pix_data = '0;
    for (int i = 0; i < int'(C_ADATA_PIXELS); i++) begin
      if (pix_idx_q == IdxW'(i)) begin
        pix_data = word_q[i*C_PIXEL_WIDTH +: C_PIXEL_WIDTH];
      end
    end
  end

  // Output beat register: reload only when the current beat is gone or absent
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (out_ready) begin
      if (pix_load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= pix_data;
        tuser_q  <= w_sof_q & (pix_idx_q == '0);
        tlast_q  <= w_eol_q & (pix_idx_q == LastIdx);
      end else begin
        tvalid_q <= 1'b0;
      end
    end
  end

  // Word holding register and pixel index; a pop overrides the final pixel step
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      word_q       <= '0;
      w_sof_q      <= 1'b0;
      w_eol_q      <= 1'b0;
      word_valid_q <= 1'b0;
      pix_idx_q    <= '0;
    end else if (!soft_resetn) begin
      word_valid_q <= 1'b0;
      pix_idx_q    <= '0;
    end else if (pop) begin
      word_q       <= fifo_dout;
      w_sof_q      <= fifo_sof;
      w_eol_q      <= fifo_eol;
      word_valid_q <= 1'b1;
      pix_idx_q    <= '0;
    end else if (pix_load) begin
      if (pix_idx_q == LastIdx) begin
        word_valid_q <= 1'b0;
        pix_idx_q    <= '0;
      end else begin
        pix_idx_q    <= pix_idx_q + IdxW'(1);
      end
    end
  end

  // Flush status stays up until soft reset is released and the bus is idle
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      resetting_q <= 1'b1;
    end else begin
      resetting_q <= ~soft_resetn | (tvalid_q & ~m_axis.TREADY);
    end
  end

endmodule

// File: tb/tb_fifo2axis_pixel.sv
// Bench for fifo2axis_pixel: a 4x8-bit DUT and a 1x32-bit passthrough DUT,
// each fed by a queue-modelled FWFT FIFO and checked against a beat scoreboard.
module tb_fifo2axis_pixel;

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eol;
  } word_t;

  typedef struct packed {
    logic [31:0] data;
    logic        user;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // DUT A: 4 pixels of 8 bits
  logic        a_soft, a_resetting, a_empty, a_sof, a_eol, a_rd_en;
  logic [31:0] a_dout;
  fifo2axis_pixel_if #(.C_PIXEL_WIDTH(8)) a_axis ();

  fifo2axis_pixel #(
    .C_PIXEL_WIDTH (8),
    .C_ADATA_PIXELS(4),
    .C_DATA_WIDTH  (32)
  ) u_dut_a (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESETN(rst_n),
    .soft_resetn   (a_soft),
    .resetting     (a_resetting),
    .fifo_empty    (a_empty),
    .fifo_sof      (a_sof),
    .fifo_eol      (a_eol),
    .fifo_dout     (a_dout),
    .fifo_rd_en    (a_rd_en),
    .m_axis        (a_axis)
  );

  // DUT B: passthrough, 1 pixel of 32 bits
  logic        b_soft, b_resetting, b_empty, b_sof, b_eol, b_rd_en;
  logic [31:0] b_dout;
  fifo2axis_pixel_if #(.C_PIXEL_WIDTH(32)) b_axis ();

  fifo2axis_pixel #(
    .C_PIXEL_WIDTH (32),
    .C_ADATA_PIXELS(1),
    .C_DATA_WIDTH  (32)
  ) u_dut_b (
    .M_AXIS_ACLK   (clk),
    .M_AXIS_ARESETN(rst_n),
    .soft_resetn   (b_soft),
    .resetting     (b_resetting),
    .fifo_empty    (b_empty),
    .fifo_sof      (b_sof),
    .fifo_eol      (b_eol),
    .fifo_dout     (b_dout),
    .fifo_rd_en    (b_rd_en),
    .m_axis        (b_axis)
  );

  word_t a_fq[$];
  word_t b_fq[$];
  beat_t a_exp[$];
  beat_t b_exp[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [3:0] rdy_pat = 4'b1001;
  bit         a_toggle = 1'b0;

  // Per-DUT tracking, sampled at the falling edge
  bit          s_a_tvalid, s_a_rd, s_a_resetting, s_b_tvalid, s_b_rd;
  bit          a_hold_pend, b_hold_pend, a_gap;
  logic [9:0]  a_hold_val;
  logic [33:0] b_hold_val;
  int          a_first_v, a_first_hs, a_last_hs, a_beats, a_pops;
  int          b_first_v, b_first_hs, b_last_hs, b_beats;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_a(input logic [31:0] d, input logic sof, input logic eol,
                        input bit expect_all);
    word_t w;
    beat_t b;
    w.d = d; w.sof = sof; w.eol = eol;
    a_fq.push_back(w);
    if (expect_all) begin
      for (int i = 0; i < 4; i++) begin
        b.data = {24'h0, d[i*8 +: 8]};
        b.user = sof && (i == 0);
        b.last = eol && (i == 3);
        a_exp.push_back(b);
      end
    end
  endtask

  task automatic push_b(input logic [31:0] d, input logic sof, input logic eol);
    word_t w;
    beat_t b;
    w.d = d; w.sof = sof; w.eol = eol;
    b_fq.push_back(w);
    b.data = d; b.user = sof; b.last = eol;
    b_exp.push_back(b);
  endtask

  task automatic reset_track();
    a_first_v = -1; a_first_hs = -1; a_last_hs = -1; a_beats = 0; a_pops = 0; a_gap = 0;
    b_first_v = -1; b_first_hs = -1; b_last_hs = -1; b_beats = 0;
  endtask

  task automatic drive_heads();
    a_empty = (a_fq.size() == 0);
    if (a_fq.size() > 0) begin
      a_dout = a_fq[0].d; a_sof = a_fq[0].sof; a_eol = a_fq[0].eol;
    end else begin
      a_dout = '0; a_sof = 1'b0; a_eol = 1'b0;
    end
    b_empty = (b_fq.size() == 0);
    if (b_fq.size() > 0) begin
      b_dout = b_fq[0].d; b_sof = b_fq[0].sof; b_eol = b_fq[0].eol;
    end else begin
      b_dout = '0; b_sof = 1'b0; b_eol = 1'b0;
    end
    if (a_toggle) a_axis.TREADY = rdy_pat[cyc % 4];
  endtask

  task automatic monitor_a();
    beat_t e;
    s_a_tvalid    = a_axis.TVALID;
    s_a_rd        = a_rd_en;
    s_a_resetting = a_resetting;
    if (a_hold_pend) begin
      check_val("a_hold_valid", 64'(a_axis.TVALID), 64'd1);
      check_val("a_hold_beat", 64'({a_axis.TUSER, a_axis.TLAST, a_axis.TDATA}),
                64'(a_hold_val));
    end
    a_hold_pend = a_axis.TVALID & ~a_axis.TREADY;
    a_hold_val  = {a_axis.TUSER, a_axis.TLAST, a_axis.TDATA};
    if (a_axis.TVALID && a_first_v < 0) a_first_v = cyc;
    if (!a_axis.TVALID && a_first_hs >= 0 && a_exp.size() > 0) a_gap = 1'b1;
    if (a_axis.TVALID && a_axis.TREADY) begin
      if (a_exp.size() == 0) begin
        check_val("a_extra_beat", 64'(a_axis.TDATA), 64'hdead_beef_0000_0000);
      end else begin
        e = a_exp.pop_front();
        check_val("a_beat", 64'({a_axis.TUSER, a_axis.TLAST, a_axis.TDATA}),
                  64'({e.user, e.last, e.data[7:0]}));
      end
      if (a_first_hs < 0) a_first_hs = cyc;
      a_last_hs = cyc;
      a_beats++;
    end
    if (a_rd_en && !a_empty) begin
      a_fq.delete(0);
      a_pops++;
    end
  endtask

  task automatic monitor_b();
    beat_t e;
    s_b_tvalid = b_axis.TVALID;
    s_b_rd     = b_rd_en;
    if (b_hold_pend) begin
      check_val("b_hold_beat", 64'({b_axis.TVALID, b_axis.TUSER, b_axis.TLAST, b_axis.TDATA}),
                64'({1'b1, b_hold_val}));
    end
    b_hold_pend = b_axis.TVALID & ~b_axis.TREADY;
    b_hold_val  = {b_axis.TUSER, b_axis.TLAST, b_axis.TDATA};
    if (b_axis.TVALID && b_first_v < 0) b_first_v = cyc;
    if (b_axis.TVALID && b_axis.TREADY) begin
      if (b_exp.size() == 0) begin
        check_val("b_extra_beat", 64'(b_axis.TDATA), 64'hdead_beef_0000_0000);
      end else begin
        e = b_exp.pop_front();
        check_val("b_beat", 64'({b_axis.TUSER, b_axis.TLAST, b_axis.TDATA}),
                  64'({e.user, e.last, e.data}));
      end
      if (b_first_hs < 0) b_first_hs = cyc;
      b_last_hs = cyc;
      b_beats++;
    end
    if (b_rd_en && !b_empty) b_fq.delete(0);
  endtask

  // One clock: drive after the rising edge, sample at the falling edge
  task automatic step();
    drive_heads();
    @(negedge clk);
    monitor_a();
    monitor_b();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (a_exp.size() == 0 && b_exp.size() == 0 && a_fq.size() == 0 && b_fq.size() == 0
          && !s_a_tvalid && !s_b_tvalid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check_val(tag, 64'd0, 64'd1);
  endtask

  initial begin
    int t0;
    bit seen;
    rst_n = 1'b0;
    a_soft = 1'b1; b_soft = 1'b1;
    a_axis.TREADY = 1'b1; b_axis.TREADY = 1'b1;
    a_hold_pend = 1'b0; b_hold_pend = 1'b0;
    reset_track();
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_val("rst_tvalid", 64'(a_axis.TVALID), 64'd0);
    check_val("rst_tuser", 64'(a_axis.TUSER), 64'd0);
    check_val("rst_tlast", 64'(a_axis.TLAST), 64'd0);
    check_val("rst_tdata", 64'(a_axis.TDATA), 64'd0);
    check_val("rst_resetting", 64'(a_resetting), 64'd1);
    check_val("rst_b_tvalid", 64'(b_axis.TVALID), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();
    check_val("rst_resetting_clear", 64'(s_a_resetting), 64'd0);

    // Single word: latency and pixel order
    reset_track();
    push_a(32'h4433_2211, 1'b1, 1'b0, 1'b1);
    t0 = cyc;
    step();
    check_val("t1_rd_en", 64'(s_a_rd), 64'd1);
    wait_idle("t1_timeout", 100);
    check_val("t1_latency", 64'(a_first_v - t0), 64'd2);
    check_val("t1_contig", 64'(a_last_hs - a_first_hs), 64'd3);

    // Three back-to-back words, one line
    reset_track();
    push_a(32'h0403_0201, 1'b1, 1'b0, 1'b1);
    push_a(32'h0807_0605, 1'b0, 1'b0, 1'b1);
    push_a(32'h0c0b_0a09, 1'b0, 1'b1, 1'b1);
    wait_idle("t2_timeout", 100);
    check_val("t2_contig", 64'(a_last_hs - a_first_hs), 64'd11);
    check_val("t2_beats", 64'(a_beats), 64'd12);
    check_val("t2_pops", 64'(a_pops), 64'd3);

    // Backpressure with TREADY pattern 1,0,0,1
    reset_track();
    a_toggle = 1'b1;
    push_a(32'h4433_2211, 1'b1, 1'b0, 1'b1);
    wait_idle("t3_timeout", 100);
    a_toggle = 1'b0;
    a_axis.TREADY = 1'b1;
    check_val("t3_beats", 64'(a_beats), 64'd4);

    // FIFO runs dry mid-line
    reset_track();
    push_a(32'h8877_6655, 1'b0, 1'b0, 1'b1);
    repeat (5) step();
    push_a(32'hccbb_aa99, 1'b0, 1'b1, 1'b1);
    wait_idle("t4_timeout", 100);
    check_val("t4_gap", 64'(a_gap), 64'd1);
    check_val("t4_beats", 64'(a_beats), 64'd8);

    // Soft reset with a stalled beat and queued words
    reset_track();
    a_axis.TREADY = 1'b0;
    push_a(32'hddcc_bbaa, 1'b1, 1'b0, 1'b0);
    begin
      beat_t b;
      b.data = 32'h0000_00aa; b.user = 1'b1; b.last = 1'b0;
      a_exp.push_back(b);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_a_tvalid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("t5_valid_seen", 64'(seen), 64'd1);
    push_a(32'h1111_1111, 1'b0, 1'b0, 1'b0);
    push_a(32'h2222_2222, 1'b0, 1'b0, 1'b0);
    push_a(32'h3333_3333, 1'b0, 1'b1, 1'b0);
    a_soft = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("t5_drain_rd_en", 64'(s_a_rd), 64'd1);
      check_val("t5_hold_valid", 64'(s_a_tvalid), 64'd1);
      check_val("t5_resetting", 64'(s_a_resetting), 64'd1);
    end
    check_val("t5_fifo_drained", 64'(a_fq.size()), 64'd0);
    a_axis.TREADY = 1'b1;
    step();
    check_val("t5_beat_taken", 64'(a_exp.size()), 64'd0);
    step();
    check_val("t5_valid_drop", 64'(s_a_tvalid), 64'd0);
    check_val("t5_resetting_low_soft", 64'(s_a_resetting), 64'd1);
    a_soft = 1'b1;
    step();
    check_val("t5_resetting_lag", 64'(s_a_resetting), 64'd1);
    step();
    check_val("t5_resetting_clear", 64'(s_a_resetting), 64'd0);
    check_val("t5_idle", 64'(s_a_tvalid), 64'd0);

    // Passthrough configuration
    reset_track();
    push_b(32'ha1b2_c3d4, 1'b1, 1'b0);
    push_b(32'h0102_0304, 1'b0, 1'b0);
    push_b(32'hffee_ddcc, 1'b0, 1'b1);
    t0 = cyc;
    wait_idle("t6_timeout", 100);
    check_val("t6_latency", 64'(b_first_v - t0), 64'd2);
    check_val("t6_contig", 64'(b_last_hs - b_first_hs), 64'd2);
    check_val("t6_beats", 64'(b_beats), 64'd3);

    check_val("end_a_exp_empty", 64'(a_exp.size()), 64'd0);
    check_val("end_b_exp_empty", 64'(b_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
